// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone device types and limits
// Purpose: response kinds, device FSM states and the wait-state ceiling.
// Ports: none (package).
package wb_pkg;

    typedef enum logic [1:0] {
        WB_RESP_ACK,
        WB_RESP_RTY,
        WB_RESP_ERR
    } wb_resp_e;

    typedef enum logic [1:0] {
        WB_DEV_IDLE,
        WB_DEV_WAIT,
        WB_DEV_RESP
    } wb_dev_state_e;

    localparam int WB_MAX_WAIT_STATES = 15;

endpackage

// File: rtl/wb_classic_fifo_device_if.sv
// rtl/wb_classic_fifo_device_if.sv - Wishbone B4 classic bus bundle
// Purpose: groups the controller-to-device handshake and data signals.
// Ports: cyc/stb/we/dat_w driven by master; dat_r/ack/err/rty driven by slave.
interface wb_classic_fifo_device_if #(
    parameter int DAT_WIDTH = 8
);
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [DAT_WIDTH-1:0] dat_w;
    logic [DAT_WIDTH-1:0] dat_r;
    logic                 ack;
    logic                 err;
    logic                 rty;

    modport master (
        output cyc, stb, we, dat_w,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, dat_w,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
// Purpose: DEPTH-entry FIFO, power-of-two depth so pointers wrap naturally.
// Ports: clk_i, rst_ni (async active-low), push_i/wdata_i, pop_i/rdata_o (head,
//        valid while not empty), level_o, full_o, empty_o.
module sync_fifo #(
    parameter int DAT_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DAT_WIDTH-1:0]       wdata_i,
    output logic [DAT_WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DAT_WIDTH-1:0] mem_q [DEPTH];
    logic [DAT_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 do_push, do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Blocked operations are dropped here so the FIFO stays consistent
        // even if a user requests push on full or pop on empty.
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

// File: rtl/wb_classic_fifo_device.sv
// rtl/wb_classic_fifo_device.sv - Wishbone classic responder fronting a FIFO
// Purpose: writes push, reads pop; registered response after WAIT_STATES+1
//          cycles; blocked accesses answered with rty (FULL_ERR=0) or err.
// Ports: clk_i, rst_ni (async active-low), wb (slave modport: cyc/stb/we/dat_w
//        in, dat_r/ack/err/rty out), level_o, full_o, empty_o.
module wb_classic_fifo_device
    import wb_pkg::*;
#(
    parameter int DAT_WIDTH   = 8,
    parameter int DEPTH       = 4,
    parameter int WAIT_STATES = 0,
    parameter bit FULL_ERR    = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    wb_classic_fifo_device_if.slave    wb,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int CNT_W = $clog2(WB_MAX_WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST =
        CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam wb_resp_e BLOCKED_RESP = FULL_ERR ? WB_RESP_ERR : WB_RESP_RTY;

    wb_dev_state_e        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [DAT_WIDTH-1:0] wdat_q, wdat_d;
    logic                 ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [DAT_WIDTH-1:0] rdat_q, rdat_d;

    logic                 enter_resp, cur_we, push, pop;
    logic [DAT_WIDTH-1:0] cur_dat, fifo_rdata;
    wb_resp_e             resp;

    sync_fifo #(.DAT_WIDTH(DAT_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (cur_dat),
        .rdata_o (fifo_rdata),
        .level_o (level_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        wdat_d     = wdat_q;
        enter_resp = 1'b0;
        // With no wait states the request is resolved on the detecting edge,
        // so the live bus values are used instead of the not-yet-latched ones.
        cur_we     = we_q;
        cur_dat    = wdat_q;
        push       = 1'b0;
        pop        = 1'b0;
        resp       = WB_RESP_ACK;
        rdat_d     = '0;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rty_d      = 1'b0;

        case (state_q)
            WB_DEV_IDLE: begin
                if (wb.cyc && wb.stb) begin
                    we_d    = wb.we;
                    wdat_d  = wb.dat_w;
                    cur_we  = wb.we;
                    cur_dat = wb.dat_w;
                    cnt_d   = '0;
                    if (WAIT_STATES == 0) enter_resp = 1'b1;
                    else                  state_d    = WB_DEV_WAIT;
                end
            end
            WB_DEV_WAIT: begin
                if (!wb.cyc)               state_d    = WB_DEV_IDLE;
                else if (cnt_q == WAIT_LAST) enter_resp = 1'b1;
                else                       cnt_d      = cnt_q + 1'b1;
            end
            WB_DEV_RESP: state_d = WB_DEV_IDLE;
            default:     state_d = WB_DEV_IDLE;
        endcase

        if (enter_resp) begin
            state_d = WB_DEV_RESP;
            if (cur_we) begin
                if (!full_o) push = 1'b1;
                else         resp = BLOCKED_RESP;
            end else begin
                if (!empty_o) begin
                    pop    = 1'b1;
                    rdat_d = fifo_rdata;
                end else begin
                    resp = BLOCKED_RESP;
                end
            end
            ack_d = (resp == WB_RESP_ACK);
            err_d = (resp == WB_RESP_ERR);
            rty_d = (resp == WB_RESP_RTY);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WB_DEV_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            rdat_q  <= rdat_d;
        end
    end

    assign wb.ack   = ack_q;
    assign wb.err   = err_q;
    assign wb.rty   = rty_q;
    assign wb.dat_r = rdat_q;

`ifdef FAKE_WB_CONTROLLER
    logic any_resp;
    assign any_resp = ack_q || err_q || rty_q;

    a_one_resp_per_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
        any_resp |=> !any_resp);
    a_resp_needs_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
        any_resp |-> (state_q == WB_DEV_RESP));
    a_resp_exclusive : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({ack_q, err_q, rty_q}));
    a_resp_follows_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == WB_DEV_IDLE && wb.cyc && wb.stb) |->
            ##[1:WAIT_STATES+1] (any_resp || state_q == WB_DEV_IDLE));
    a_level_bound : assert property (@(posedge clk_i)
        level_o <= ($clog2(DEPTH+1))'(DEPTH));
`endif
endmodule

// File: tb/tb_wb_classic_fifo_device.sv
// tb/tb_wb_classic_fifo_device.sv - self-checking bench for wb_classic_fifo_device
module tb_wb_classic_fifo_device;
    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_ACK  = 3'b100;
    localparam logic [2:0] R_ERR  = 3'b010;
    localparam logic [2:0] R_RTY  = 3'b001;

    typedef struct {
        logic [2:0] resp;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [7:0] dat = 8'h00;
    int         sel = 0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mq[$];
    exp_t       sb[$];

    always #5 clk = ~clk;

    wb_classic_fifo_device_if #(.DAT_WIDTH(8)) wb0 ();
    wb_classic_fifo_device_if #(.DAT_WIDTH(8)) wb1 ();
    wb_classic_fifo_device_if #(.DAT_WIDTH(8)) wb2 ();

    assign wb0.cyc = cyc && (sel == 0);
    assign wb0.stb = stb && (sel == 0);
    assign wb0.we  = we;
    assign wb0.dat_w = dat;
    assign wb1.cyc = cyc && (sel == 1);
    assign wb1.stb = stb && (sel == 1);
    assign wb1.we  = we;
    assign wb1.dat_w = dat;
    assign wb2.cyc = cyc && (sel == 2);
    assign wb2.stb = stb && (sel == 2);
    assign wb2.we  = we;
    assign wb2.dat_w = dat;

    logic [2:0] lvl0, lvl1, lvl2;
    logic       full0, full1, full2, empty0, empty1, empty2;

    wb_classic_fifo_device #(.DAT_WIDTH(8), .DEPTH(4), .WAIT_STATES(0), .FULL_ERR(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .wb(wb0.slave),
        .level_o(lvl0), .full_o(full0), .empty_o(empty0));
    wb_classic_fifo_device #(.DAT_WIDTH(8), .DEPTH(4), .WAIT_STATES(0), .FULL_ERR(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .wb(wb1.slave),
        .level_o(lvl1), .full_o(full1), .empty_o(empty1));
    wb_classic_fifo_device #(.DAT_WIDTH(8), .DEPTH(4), .WAIT_STATES(3), .FULL_ERR(1'b0)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .wb(wb2.slave),
        .level_o(lvl2), .full_o(full2), .empty_o(empty2));

    logic [2:0] o_resp, o_lvl;
    logic [7:0] o_dat;
    logic       o_full, o_empty;

    always_comb begin
        o_resp = {wb0.ack, wb0.err, wb0.rty};
        o_dat = wb0.dat_r; o_lvl = lvl0; o_full = full0; o_empty = empty0;
        if (sel == 1) begin
            o_resp = {wb1.ack, wb1.err, wb1.rty};
            o_dat = wb1.dat_r; o_lvl = lvl1; o_full = full1; o_empty = empty1;
        end else if (sel == 2) begin
            o_resp = {wb2.ack, wb2.err, wb2.rty};
            o_dat = wb2.dat_r; o_lvl = lvl2; o_full = full2; o_empty = empty2;
        end
    end

    task automatic apply_reset(input int s);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; dat = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sel = s;
        mq.delete();
        sb.delete();
    endtask

    // One request held until its response; compares every cycle against the
    // scoreboard entry predicted from the bench's own FIFO model.
    task automatic do_txn(input logic w, input logic [7:0] d, input int ws, input string nm);
        exp_t       e;
        logic [2:0] blk;
        blk = (sel == 1) ? R_ERR : R_RTY;
        e.data = 8'h00;
        if (w) begin
            if (mq.size() < 4) begin mq.push_back(d); e.resp = R_ACK; end
            else e.resp = blk;
        end else begin
            if (mq.size() > 0) begin e.data = mq.pop_front(); e.resp = R_ACK; end
            else e.resp = blk;
        end
        sb.push_back(e);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; dat = d;
        for (int k = 1; k <= ws + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= ws) begin
                n_cmp++;
                if (o_resp !== R_NONE || o_dat !== 8'h00) begin
                    n_bad++;
                    $display("FAIL %s early cycle %0d: resp=%b dat=%h required resp=000 dat=00", nm, k, o_resp, o_dat);
                end
            end else begin
                exp_t x;
                x = sb.pop_front();
                n_cmp++;
                if (o_resp !== x.resp || o_dat !== x.data) begin
                    n_bad++;
                    $display("FAIL %s resp cycle %0d: resp=%b dat=%h required resp=%b dat=%h", nm, k, o_resp, o_dat, x.resp, x.data);
                end
                n_cmp++;
                if (o_lvl !== 3'(mq.size()) || o_full !== (mq.size() == 4) || o_empty !== (mq.size() == 0)) begin
                    n_bad++;
                    $display("FAIL %s status: level=%0d full=%b empty=%b required level=%0d", nm, o_lvl, o_full, o_empty, mq.size());
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset(0);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_cmp++;
            if (o_resp !== R_NONE || o_dat !== 8'h00 || o_lvl !== 3'd0 || o_full !== 1'b0 || o_empty !== 1'b1) begin
                n_bad++;
                $display("FAIL reset dut%0d: resp=%b dat=%h lvl=%0d full=%b empty=%b", s, o_resp, o_dat, o_lvl, o_full, o_empty);
            end
        end
        sel = 0;
    endtask

    task automatic test_single_write;
        apply_reset(0);
        do_txn(1'b1, 8'hA5, 0, "single_write");
    endtask

    task automatic test_fill_drain;
        logic [7:0] v [4];
        v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h44;
        apply_reset(0);
        for (int i = 0; i < 4; i++) do_txn(1'b1, v[i], 0, "fill");
        do_txn(1'b1, 8'h55, 0, "write_full_rty");
        for (int i = 0; i < 4; i++) do_txn(1'b0, 8'h00, 0, "drain");
        do_txn(1'b0, 8'h00, 0, "read_empty_rty");
    endtask

    task automatic test_full_err;
        apply_reset(1);
        for (int i = 0; i < 4; i++) do_txn(1'b1, 8'(8'h80 + i), 0, "err_fill");
        do_txn(1'b1, 8'h55, 0, "write_full_err");
        for (int i = 0; i < 4; i++) do_txn(1'b0, 8'h00, 0, "err_drain");
        do_txn(1'b0, 8'h00, 0, "read_empty_err");
    endtask

    task automatic test_wait_abort;
        apply_reset(2);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; dat = 8'h77;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (o_resp !== R_NONE || o_lvl !== 3'd0) begin
                n_bad++;
                $display("FAIL abort cycle %0d: resp=%b lvl=%0d required resp=000 lvl=0", k, o_resp, o_lvl);
            end
        end
        do_txn(1'b1, 8'h3C, 3, "wait_write");
    endtask

    task automatic test_async_reset;
        sel = 2;
        n_cmp++;
        if (o_lvl !== 3'(mq.size()) || mq.size() != 1) begin
            n_bad++;
            $display("FAIL pre_reset level=%0d required 1", o_lvl);
        end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; dat = 8'h99;
        @(posedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_resp !== R_NONE || o_dat !== 8'h00 || o_lvl !== 3'd0 || o_full !== 1'b0 || o_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: resp=%b dat=%h lvl=%0d full=%b empty=%b", o_resp, o_dat, o_lvl, o_full, o_empty);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        sb.delete();
        do_txn(1'b1, 8'h5A, 3, "post_reset_write");
    endtask

    task automatic test_back_to_back;
        exp_t e;
        apply_reset(0);
        for (int i = 0; i < 3; i++) begin
            mq.push_back(8'(8'h60 + 2 * i));
            e.resp = R_ACK; e.data = 8'h00;
            sb.push_back(e);
        end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; dat = 8'h60;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); @(negedge clk);
            if (k % 2 == 1) begin
                exp_t x;
                x = sb.pop_front();
                n_cmp++;
                if (o_resp !== x.resp || o_lvl !== 3'((k + 1) / 2)) begin
                    n_bad++;
                    $display("FAIL b2b cycle %0d: resp=%b lvl=%0d required resp=%b lvl=%0d", k, o_resp, o_lvl, x.resp, (k + 1) / 2);
                end
            end else begin
                n_cmp++;
                if (o_resp !== R_NONE) begin
                    n_bad++;
                    $display("FAIL b2b gap cycle %0d: resp=%b required 000", k, o_resp);
                end
            end
            dat = 8'(8'h60 + k);
        end
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 3; i++) do_txn(1'b0, 8'h00, 0, "b2b_readback");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_fill_drain();
        test_full_err();
        test_wait_abort();
        test_async_reset();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard leftover entries=%0d required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
